// File: rtl/chiplib_pri_queue_push_arb.sv
// Round-robin arbiter feeding a one-entry registered push stage for the priority queue.
// Define CHIPLIB_PRI_QUEUE_PUSH_ARB_PRI_AWARE_EN to pick the highest-priority requester instead.
module chiplib_pri_queue_push_arb #(
  parameter int NumReq        = 4,
  parameter int DataWidth     = 64,
  parameter int PriorityWidth = 16,
  localparam int IdxWidth     = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NumReq-1:0]               req_valid,
  output logic [NumReq-1:0]               req_ready,
  input  logic [NumReq*DataWidth-1:0]     req_data,
  input  logic [NumReq*PriorityWidth-1:0] req_pri,
  output logic                            push_valid,
  input  logic                            push_ready,
  output logic [DataWidth-1:0]            push_data,
  output logic [PriorityWidth-1:0]        push_pri,
  output logic [IdxWidth-1:0]             push_src
);

  logic                     push_valid_q, push_valid_d;
  logic [DataWidth-1:0]     push_data_q, push_data_d;
  logic [PriorityWidth-1:0] push_pri_q, push_pri_d;
  logic [IdxWidth-1:0]      push_src_q, push_src_d;
  logic [IdxWidth-1:0]      rr_ptr_q, rr_ptr_d;

  logic                     load;
  logic                     any_valid;
  logic                     grant_en;
  logic [IdxWidth-1:0]      win_idx;

  logic [DataWidth-1:0]     req_data_arr [NumReq];
  logic [PriorityWidth-1:0] req_pri_arr  [NumReq];

  for (genvar gi = 0; gi < NumReq; gi++) begin : g_unpack
    assign req_data_arr[gi] = req_data[gi*DataWidth +: DataWidth];
    assign req_pri_arr[gi]  = req_pri[gi*PriorityWidth +: PriorityWidth];
  end

  // Scan in round-robin order starting at rr_ptr; the first hit (or first strictly
  // higher priority) wins, so priority ties resolve in round-robin order.
  always_comb begin
    int                       idx;
    logic [IdxWidth-1:0]      cand;
`ifdef CHIPLIB_PRI_QUEUE_PUSH_ARB_PRI_AWARE_EN
    logic [PriorityWidth-1:0] best_pri;
    best_pri  = '0;
`endif
    any_valid = 1'b0;
    win_idx   = '0;
    idx       = 0;
    cand      = '0;
    for (int k = 0; k < NumReq; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NumReq) idx = idx - NumReq;
      cand = IdxWidth'(idx);
      if (req_valid[cand]) begin
`ifdef CHIPLIB_PRI_QUEUE_PUSH_ARB_PRI_AWARE_EN
        if (!any_valid || (req_pri_arr[cand] > best_pri)) begin
          any_valid = 1'b1;
          win_idx   = cand;
          best_pri  = req_pri_arr[cand];
        end
`else
        if (!any_valid) begin
          any_valid = 1'b1;
          win_idx   = cand;
        end
`endif
      end
    end
  end

  assign load     = ~push_valid_q | push_ready;
  assign grant_en = load & any_valid & ~rst;

  for (genvar gi = 0; gi < NumReq; gi++) begin : g_ready
    assign req_ready[gi] = grant_en & (win_idx == IdxWidth'(gi));
  end

  always_comb begin
    push_valid_d = push_valid_q;
    push_data_d  = push_data_q;
    push_pri_d   = push_pri_q;
    push_src_d   = push_src_q;
    rr_ptr_d     = rr_ptr_q;
    if (grant_en) begin
      push_valid_d = 1'b1;
      push_data_d  = req_data_arr[win_idx];
      push_pri_d   = req_pri_arr[win_idx];
      push_src_d   = win_idx;
      // Explicit wrap keeps non-power-of-two requester counts correct.
      rr_ptr_d     = (win_idx == IdxWidth'(NumReq - 1)) ? '0 : win_idx + 1'b1;
    end else if (push_valid_q && push_ready) begin
      push_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      push_valid_q <= 1'b0;
      push_data_q  <= '0;
      push_pri_q   <= '0;
      push_src_q   <= '0;
      rr_ptr_q     <= '0;
    end else begin
      push_valid_q <= push_valid_d;
      push_data_q  <= push_data_d;
      push_pri_q   <= push_pri_d;
      push_src_q   <= push_src_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

  assign push_valid = push_valid_q;
  assign push_data  = push_data_q;
  assign push_pri   = push_pri_q;
  assign push_src   = push_src_q;

endmodule

// File: tb/tb_chiplib_pri_queue_push_arb.sv
// Self-checking bench: directed steps plus randomized traffic against a behavioural model.
module tb_chiplib_pri_queue_push_arb;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int PW = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_data = '0;
  logic [N*PW-1:0] req_pri = '0;
  logic            push_valid;
  logic            push_ready = 1'b0;
  logic [DW-1:0]   push_data;
  logic [PW-1:0]   push_pri;
  logic [1:0]      push_src;

  // Three-requester instance for the non-power-of-two wrap.
  logic [2:0]  r3_valid = '0;
  logic [2:0]  r3_ready;
  logic [23:0] r3_data = 24'h332211;
  logic [11:0] r3_pri = '0;
  logic        p3_valid;
  logic        p3_ready = 1'b0;
  logic [7:0]  p3_data;
  logic [3:0]  p3_pri;
  logic [1:0]  p3_src;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  bit            m_valid = 1'b0;
  logic [DW-1:0] m_data  = '0;
  logic [PW-1:0] m_pri   = '0;
  int            m_src   = 0;
  int            m_ptr   = 0;

  always #5 clk = ~clk;

  chiplib_pri_queue_push_arb #(.NumReq(N), .DataWidth(DW), .PriorityWidth(PW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_pri(req_pri), .push_valid(push_valid),
    .push_ready(push_ready), .push_data(push_data), .push_pri(push_pri),
    .push_src(push_src)
  );

  chiplib_pri_queue_push_arb #(.NumReq(3), .DataWidth(8), .PriorityWidth(4)) dut3 (
    .clk(clk), .rst(rst), .req_valid(r3_valid), .req_ready(r3_ready),
    .req_data(r3_data), .req_pri(r3_pri), .push_valid(p3_valid),
    .push_ready(p3_ready), .push_data(p3_data), .push_pri(p3_pri),
    .push_src(p3_src)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int pri_of(input int i);
    return int'(req_pri[i*PW +: PW]);
  endfunction

  // Winner per the arbitration rules; -1 when nobody is valid.
  function automatic int model_winner(input logic [N-1:0] v);
`ifdef CHIPLIB_PRI_QUEUE_PUSH_ARB_PRI_AWARE_EN
    int maxp = -1;
    for (int i = 0; i < N; i++)
      if (v[i] && pri_of(i) > maxp) maxp = pri_of(i);
    for (int k = 0; k < N; k++)
      if (v[(m_ptr + k) % N] && pri_of((m_ptr + k) % N) == maxp) return (m_ptr + k) % N;
    return -1;
`else
    for (int k = 0; k < N; k++)
      if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
`endif
  endfunction

  task automatic rand_payload();
    for (int i = 0; i < N; i++) begin
      req_data[i*DW +: DW] = {$urandom, $urandom};
      req_pri[i*PW +: PW]  = 16'($urandom_range(0, 7));
    end
  endtask

  // One cycle: drive, check outputs at the falling edge, advance the model, return at posedge+1.
  task automatic step(input logic [N-1:0] v, input logic pr);
    int         w;
    bit         ld;
    logic [N-1:0] exp_ready;
    req_valid  = v;
    push_ready = pr;
    @(negedge clk);
    w  = model_winner(v);
    ld = !m_valid || pr;
    exp_ready = (ld && w >= 0) ? N'(1 << w) : '0;
    chk("push_valid", 64'(push_valid), 64'(m_valid));
    if (m_valid) begin
      chk("push_data", push_data, m_data);
      chk("push_pri", 64'(push_pri), 64'(m_pri));
      chk("push_src", 64'(push_src), 64'(m_src));
    end
    chk("req_ready", 64'(req_ready), 64'(exp_ready));
    if (m_valid && pr)
      $display("push src=%0d data=%h pri=%0d", m_src, m_data, m_pri);
    if (ld && w >= 0) begin
      m_valid = 1'b1;
      m_data  = req_data[w*DW +: DW];
      m_pri   = req_pri[w*PW +: PW];
      m_src   = w;
      m_ptr   = (w + 1) % N;
    end else if (m_valid && pr) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset values while reset is held.
    req_valid = '1;
    #3;
    chk("rst_push_valid", 64'(push_valid), 64'(0));
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_push_src", 64'(push_src), 64'(0));
    chk("rst_push_data", push_data, 64'(0));
    chk("rst_push_pri", 64'(push_pri), 64'(0));
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // All valid with push_ready held: one push per cycle in order 0,1,2,3,0.
    for (int i = 0; i < 5; i++) begin
      rand_payload();
      step(4'b1111, 1'b1);
`ifndef CHIPLIB_PRI_QUEUE_PUSH_ARB_PRI_AWARE_EN
      chk("rr_seq_src", 64'(push_src), 64'(i % N));
`endif
    end

    // Entry from req 2 held while the queue is full.
    step(4'b0100, 1'b1);
    chk("hold_src", 64'(push_src), 64'(2));
    for (int i = 0; i < 5; i++) begin
      rand_payload();
      step(4'b1111, 1'b0);
    end
    rand_payload();
    step(4'b1111, 1'b1);
`ifndef CHIPLIB_PRI_QUEUE_PUSH_ARB_PRI_AWARE_EN
    chk("after_hold_src", 64'(push_src), 64'(3));
`endif

    // Single requester then another, no bubble.
    step(4'b0000, 1'b1);
    req_data[1*DW +: DW] = 64'hA5;
    req_pri[1*PW +: PW]  = 16'd7;
    step(4'b0010, 1'b1);
    chk("single_data", push_data, 64'hA5);
    chk("single_src", 64'(push_src), 64'(1));
    step(4'b1000, 1'b1);
    chk("next_src", 64'(push_src), 64'(3));
    chk("no_bubble", 64'(push_valid), 64'(1));
    step(4'b0000, 1'b1);

`ifdef CHIPLIB_PRI_QUEUE_PUSH_ARB_PRI_AWARE_EN
    // rr_ptr is 0 here; a win by req 1 moves it to 2.
    step(4'b0010, 1'b1);
    req_pri = {16'd5, 16'd40, 16'd40, 16'd10};
    step(4'b1111, 1'b1);
    chk("pri_win0", 64'(push_src), 64'(2));
    step(4'b1011, 1'b1);
    chk("pri_win1", 64'(push_src), 64'(1));
    step(4'b1001, 1'b1);
    chk("pri_win2", 64'(push_src), 64'(0));
    step(4'b1000, 1'b1);
    chk("pri_win3", 64'(push_src), 64'(3));
    step(4'b0000, 1'b1);
`endif

    // Asynchronous reset in the middle of a cycle discards the held entry.
    rand_payload();
    step(4'b0110, 1'b0);
    req_valid = 4'b1111;
    #2 rst = 1'b1;
    #1;
    chk("arst_push_valid", 64'(push_valid), 64'(0));
    chk("arst_req_ready", 64'(req_ready), 64'(0));
    chk("arst_push_src", 64'(push_src), 64'(0));
    chk("arst_push_data", push_data, 64'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    m_valid = 1'b0;
    m_data  = '0;
    m_pri   = '0;
    m_src   = 0;
    m_ptr   = 0;

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      rand_payload();
      step(N'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
    end
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);

    // Three requesters: req 2 wins, pointer wraps to 0.
    r3_valid = 3'b100;
    p3_ready = 1'b1;
    @(negedge clk);
    chk("n3_ready_first", 64'(r3_ready), 64'(3'b100));
    @(posedge clk);
    #1;
    chk("n3_src_first", 64'(p3_src), 64'(2));
    chk("n3_data_first", 64'(p3_data), 64'h33);
    r3_valid = 3'b111;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("n3_wrap_src", 64'(p3_src), 64'(i % 3));
      chk("n3_wrap_data", 64'(p3_data), 64'(8'h11 * (i % 3 + 1)));
    end
    r3_valid = 3'b000;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
